// File: rtl/up_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// up_down_counter_pkg
// Shared types for the parametrised up/down counter.
//   dir_e      : count direction, bit-compatible with the up_down input
//   cnt_op_e   : result of the per-edge priority decode (clear > load > step)
// Optional build macro (used by importers): UPDN_COUNTER_SATURATE_EN
// -----------------------------------------------------------------------------
package up_down_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD,
    OP_CLEAR
  } cnt_op_e;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter_next.sv
// -----------------------------------------------------------------------------
// up_down_counter_next
// Purely combinational next-count generator for up_down_counter.
// Ports:
//   count_i    : current registered count
//   load_val_i : parallel load value (clamped to MAX_VAL)
//   op_i       : decoded operation for this edge
//   dir_i      : step direction
//   count_o    : count value to register on the next edge
//   wrap_up_o  : up-count boundary event (wrap, or blocked step when saturating)
//   wrap_dn_o  : down-count boundary event (wrap, or blocked step when saturating)
// Build macro: UPDN_COUNTER_SATURATE_EN selects saturation at the boundaries
// instead of wrap-around. Boundary events are flagged in both modes.
// -----------------------------------------------------------------------------
module up_down_counter_next
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  cnt_op_e          op_i,
  input  dir_e             dir_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_up_o,
  output logic             wrap_dn_o
);

  // Math is done one bit wider so that +1 at the all-ones value never wraps
  // silently; the only legal wrap points are MAX_VAL and zero.
  localparam logic [WIDTH:0] MaxExt = (WIDTH + 1)'(MAX_VAL);

  logic [WIDTH:0] countExt;
  logic [WIDTH:0] loadExt;
  logic [WIDTH:0] nextExt;

  assign countExt = {1'b0, count_i};
  assign loadExt  = {1'b0, load_val_i};

  // Select the next count from the decoded operation. Boundary events are
  // raised only for an actual step at a boundary, so clear/load never pulse.
  always_comb begin
    nextExt   = countExt;
    wrap_up_o = 1'b0;
    wrap_dn_o = 1'b0;
    unique case (op_i)
      OP_CLEAR: nextExt = '0;
      OP_LOAD:  nextExt = (loadExt > MaxExt) ? MaxExt : loadExt;
      OP_STEP: begin
        if (dir_i == DIR_UP) begin
          if (countExt == MaxExt) begin
`ifdef UPDN_COUNTER_SATURATE_EN
            nextExt = MaxExt;
`else
            nextExt = '0;
`endif
            wrap_up_o = 1'b1;
          end else begin
            nextExt = countExt + 1'b1;
          end
        end else begin
          if (countExt == '0) begin
`ifdef UPDN_COUNTER_SATURATE_EN
            nextExt = '0;
`else
            nextExt = MaxExt;
`endif
            wrap_dn_o = 1'b1;
          end else begin
            nextExt = countExt - 1'b1;
          end
        end
      end
      default: nextExt = countExt;
    endcase
  end

  assign count_o = nextExt[WIDTH-1:0];

endmodule : up_down_counter_next

// File: rtl/up_down_counter.sv
// -----------------------------------------------------------------------------
// up_down_counter
// Parametrised modulo-(MAX_VAL+1) up/down counter with enable, synchronous
// clear, clamped parallel load, registered boundary flags and one-cycle wrap
// event pulses.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset (count <= RESET_VAL)
//   en       : count enable
//   up_down  : 1 = count up, 0 = count down
//   clear    : synchronous clear to 0 (highest priority)
//   load     : synchronous load of min(load_val, MAX_VAL)
//   load_val : value to load
//   count    : registered count
//   at_max   : count == MAX_VAL
//   at_min   : count == 0
//   wrap_up  : registered up-boundary event pulse
//   wrap_dn  : registered down-boundary event pulse
// Build macro: UPDN_COUNTER_SATURATE_EN (saturate instead of wrap).
// -----------------------------------------------------------------------------
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MAX_VAL   = (1 << WIDTH) - 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_up,
  output logic             wrap_dn
);

  localparam logic [WIDTH-1:0] MaxCount   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ResetCount = WIDTH'(RESET_VAL);

  cnt_op_e          opSel;
  dir_e             dirSel;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapUp_q, wrapUp_d;
  logic             wrapDn_q, wrapDn_d;

  // Priority decode of the control inputs: clear beats load, load beats a
  // step, and a step needs en. Anything else holds the count.
  always_comb begin
    opSel = OP_HOLD;
    if (clear) begin
      opSel = OP_CLEAR;
    end else if (load) begin
      opSel = OP_LOAD;
    end else if (en) begin
      opSel = OP_STEP;
    end
  end

  assign dirSel = dir_e'(up_down);

  up_down_counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count_i    (count_q),
    .load_val_i (load_val),
    .op_i       (opSel),
    .dir_i      (dirSel),
    .count_o    (count_d),
    .wrap_up_o  (wrapUp_d),
    .wrap_dn_o  (wrapDn_d)
  );

  // Count and event registers. The event bits are registered alongside the
  // count so a pulse lines up with the cycle that shows the wrapped value;
  // reset drops any pulse that was about to be seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= ResetCount;
      wrapUp_q <= 1'b0;
      wrapDn_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrapUp_q <= wrapUp_d;
      wrapDn_q <= wrapDn_d;
    end
  end

  // Flags are decoded from the register only, keeping inputs off the
  // output timing path.
  assign count   = count_q;
  assign at_max  = (count_q == MaxCount);
  assign at_min  = (count_q == '0);
  assign wrap_up = wrapUp_q;
  assign wrap_dn = wrapDn_q;

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// -----------------------------------------------------------------------------
// tb_up_down_counter
// Directed self-checking bench for up_down_counter with WIDTH=3, MAX_VAL=5,
// RESET_VAL=2. Scenarios under UPDN_COUNTER_SATURATE_EN are compiled in only
// when that macro is defined for the build.
// -----------------------------------------------------------------------------
module tb_up_down_counter;

  localparam int WIDTH     = 3;
  localparam int MAX_VAL   = 5;
  localparam int RESET_VAL = 2;

  logic             clk;
  logic             reset;
  logic             en;
  logic             upDown;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] loadVal;
  logic [WIDTH-1:0] count;
  logic             atMax;
  logic             atMin;
  logic             wrapUp;
  logic             wrapDn;

  int nChecks = 0;
  int nFail   = 0;

  up_down_counter #(
    .WIDTH     (WIDTH),
    .MAX_VAL   (MAX_VAL),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_down  (upDown),
    .clear    (clear),
    .load     (load),
    .load_val (loadVal),
    .count    (count),
    .at_max   (atMax),
    .at_min   (atMin),
    .wrap_up  (wrapUp),
    .wrap_dn  (wrapDn)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive all synchronous controls at once.
  task automatic applyStimulus(input logic clr, input logic ld, input logic [WIDTH-1:0] ldv,
                               input logic enable, input logic up);
    clear   = clr;
    load    = ld;
    loadVal = ldv;
    en      = enable;
    upDown  = up;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset value, asynchronous assertion mid-count, and pulse dropping.
  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    tick();
    if (count !== 3'd2) begin $display("[TB] FAIL reset_count: got %0d expected 2", count); nFail++; end
    nChecks++;
    if ({wrapUp, wrapDn, atMax, atMin} !== 4'b0000) begin
      $display("[TB] FAIL reset_flags: got %b expected 0000", {wrapUp, wrapDn, atMax, atMin}); nFail++;
    end
    nChecks++;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    tick();
    if (count !== 3'd4) begin $display("[TB] FAIL precount: got %0d expected 4", count); nFail++; end
    nChecks++;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    if (count !== 3'd2) begin $display("[TB] FAIL async_reset_count: got %0d expected 2", count); nFail++; end
    nChecks++;
    if ({wrapUp, wrapDn} !== 2'b00) begin
      $display("[TB] FAIL async_reset_pulses: got %b expected 00", {wrapUp, wrapDn}); nFail++;
    end
    nChecks++;
    #1 reset = 1'b0;

    // Pending pulse is dropped by reset.
    applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    if (wrapUp !== 1'b1) begin $display("[TB] FAIL pending_pulse: got %b expected 1", wrapUp); nFail++; end
    nChecks++;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    if ({count, wrapUp} !== {3'd2, 1'b0}) begin
      $display("[TB] FAIL reset_drops_pulse: got count=%0d wrap_up=%b expected count=2 wrap_up=0", count, wrapUp); nFail++;
    end
    nChecks++;
    #1 reset = 1'b0;
  endtask

  // Modulo up-count from 0 through the MAX_VAL wrap.
  task automatic test_up_count();
    logic [WIDTH-1:0] expCnt [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    tick();
    if ({count, atMin} !== {3'd0, 1'b1}) begin
      $display("[TB] FAIL up_start: got count=%0d at_min=%b expected 0/1", count, atMin); nFail++;
    end
    nChecks++;
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (count !== expCnt[i]) begin
        $display("[TB] FAIL up_count[%0d]: got %0d expected %0d", i, count, expCnt[i]); nFail++;
      end
      nChecks++;
      if ({wrapUp, wrapDn} !== {(i == 5), 1'b0}) begin
        $display("[TB] FAIL up_pulse[%0d]: got %b expected %b", i, {wrapUp, wrapDn}, {(i == 5), 1'b0}); nFail++;
      end
      nChecks++;
      if (atMax !== (i == 4)) begin
        $display("[TB] FAIL up_at_max[%0d]: got %b expected %b", i, atMax, (i == 4)); nFail++;
      end
      nChecks++;
    end
  endtask

  // Down-count from 1 through the zero wrap.
  task automatic test_down_count();
    logic [WIDTH-1:0] expCnt [3] = '{3'd0, 3'd5, 3'd4};
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (count !== expCnt[i]) begin
        $display("[TB] FAIL down_count[%0d]: got %0d expected %0d", i, count, expCnt[i]); nFail++;
      end
      nChecks++;
      if ({wrapUp, wrapDn} !== {1'b0, (i == 1)}) begin
        $display("[TB] FAIL down_pulse[%0d]: got %b expected %b", i, {wrapUp, wrapDn}, {1'b0, (i == 1)}); nFail++;
      end
      nChecks++;
      if (atMin !== (i == 0)) begin
        $display("[TB] FAIL down_at_min[%0d]: got %b expected %b", i, atMin, (i == 0)); nFail++;
      end
      nChecks++;
    end
  endtask

  // Clear over load over step, load clamping, and a suppressed wrap.
  task automatic test_priority();
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
    tick();
    if (count !== 3'd0) begin $display("[TB] FAIL clear_priority: got %0d expected 0", count); nFail++; end
    nChecks++;
    applyStimulus(1'b0, 1'b1, 3'd7, 1'b0, 1'b1);
    tick();
    if ({count, atMax, wrapUp, wrapDn} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL load_clamp: got count=%0d flags=%b expected count=5 flags=100",
               count, {atMax, wrapUp, wrapDn}); nFail++;
    end
    nChecks++;
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    tick();
    if ({count, wrapUp} !== {3'd2, 1'b0}) begin
      $display("[TB] FAIL load_over_wrap: got count=%0d wrap_up=%b expected 2/0", count, wrapUp); nFail++;
    end
    nChecks++;
  endtask

  // en low holds regardless of direction.
  task automatic test_hold();
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, i[0]);
      tick();
      if ({count, wrapUp, wrapDn} !== {3'd3, 1'b0, 1'b0}) begin
        $display("[TB] FAIL hold[%0d]: got count=%0d pulses=%b expected 3/00", i, count, {wrapUp, wrapDn}); nFail++;
      end
      nChecks++;
    end
  endtask

  // Direction reversal on consecutive edges with no dead cycle.
  task automatic test_back_to_back();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    if (count !== 3'd4) begin $display("[TB] FAIL b2b_up: got %0d expected 4", count); nFail++; end
    nChecks++;
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    if (count !== 3'd3) begin $display("[TB] FAIL b2b_down: got %0d expected 3", count); nFail++; end
    nChecks++;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

`ifdef UPDN_COUNTER_SATURATE_EN
  // Blocked steps at the boundaries hold the count and pulse every time.
  task automatic test_saturate();
    applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      if ({count, wrapUp, wrapDn} !== {3'd5, 1'b1, 1'b0}) begin
        $display("[TB] FAIL sat_up[%0d]: got count=%0d pulses=%b expected 5/10", i, count, {wrapUp, wrapDn}); nFail++;
      end
      nChecks++;
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    if ({count, wrapUp, wrapDn} !== {3'd0, 1'b0, 1'b1}) begin
      $display("[TB] FAIL sat_down: got count=%0d pulses=%b expected 0/01", count, {wrapUp, wrapDn}); nFail++;
    end
    nChecks++;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    if ({count, wrapUp, wrapDn} !== {3'd0, 1'b0, 1'b0}) begin
      $display("[TB] FAIL sat_settle: got count=%0d pulses=%b expected 0/00", count, {wrapUp, wrapDn}); nFail++;
    end
    nChecks++;
  endtask
`endif

  initial begin
    $display("[TB] up_down_counter bench start");
    test_reset();
    test_up_count();
    test_down_count();
    test_priority();
    test_hold();
    test_back_to_back();
`ifdef UPDN_COUNTER_SATURATE_EN
    test_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule : tb_up_down_counter

// File: doc/up_down_counter.md
Name: up_down_counter

Overview:
Parametrised successor to the 3-bit up/down counter. Adds configurable width, a programmable terminal value (modulo-N counting), count enable, synchronous clear and parallel load. Adds registered boundary flags and one-cycle wrap event pulses. Used as a generic event/position counter feeding display, timing and control FSMs elsewhere in the lab designs.

Parameters:
- WIDTH, 3, counter width in bits; must be at least 1.
- MAX_VAL, 2**WIDTH-1, terminal (highest) count value; must satisfy 0 < MAX_VAL <= 2**WIDTH-1.
- RESET_VAL, 0, count value applied on reset; must satisfy RESET_VAL <= MAX_VAL.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  count enable; count steps only when high
- up_down  input  1  direction: 1 = count up, 0 = count down
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value to load
- count  output  WIDTH  current count (registered)
- at_max  output  1  high while count == MAX_VAL
- at_min  output  1  high while count == 0
- wrap_up  output  1  one-cycle pulse on an up-count boundary event
- wrap_dn  output  1  one-cycle pulse on a down-count boundary event

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port reset. Reset asserts immediately, independent of clk.
- Reset values: count = RESET_VAL; wrap_up = 0; wrap_dn = 0. at_max and at_min follow from count.
- Per-edge priority, evaluated at each rising clk edge when reset is low:
  - clear: count <= 0.
  - else load: count <= min(load_val, MAX_VAL). Load values above MAX_VAL clamp to MAX_VAL.
  - else en && up_down: if count == MAX_VAL, count <= 0 and a wrap_up event occurs; otherwise count <= count + 1.
  - else en && !up_down: if count == 0, count <= MAX_VAL and a wrap_dn event occurs; otherwise count <= count - 1.
  - else: count holds.
- Wrap pulses:
  - wrap_up/wrap_dn are registered and high for exactly the one cycle in which count first shows the wrapped value.
  - They are low on every cycle with no event, including cycles where clear or load took priority over a would-be wrap.
- Flags: at_max and at_min are decoded from the count register only (no input-to-output combinational path). Both are high when MAX_VAL... never; MAX_VAL > 0, so they are never high together.
- Arithmetic: next-value math is carried out in WIDTH+1 bits, then truncated. No implicit wrap at 2**WIDTH; the only wrap points are MAX_VAL and 0.
- Latency: one cycle from the input edge to count, the flags and the pulses.
- Reset mid-operation: count returns to RESET_VAL at once; any pending pulse is dropped.
- Direction change: takes effect on the same edge, with no dead cycle.

Optional Feature:
Macro UPDN_COUNTER_SATURATE_EN.
- Defined: saturating mode.
  - An up-count at MAX_VAL holds count at MAX_VAL; a down-count at 0 holds count at 0.
  - wrap_up/wrap_dn pulse on the cycle after such a blocked step, flagging a saturation attempt.
  - All other behaviour is unchanged.
- Undefined: wrap-around behaviour as described above.

Decomposition:
- Package up_down_counter_pkg:
  - typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e.
  - typedef enum logic [1:0] {OP_HOLD, OP_STEP, OP_LOAD, OP_CLEAR} cnt_op_e, used for the priority decode.
- One combinational sub-module, up_down_counter_next. Inputs: count, op, dir. Outputs: next count and the two event bits. The saturate macro is honoured inside this sub-module.
- Top level holds the registers and the flag decode.

Test Plan:
- Reset: assert reset mid-count at count=4 (WIDTH=3, RESET_VAL=2) -> count=2 immediately, before the next clk edge; wrap_up=0 and wrap_dn=0.
- Modulo up-count: WIDTH=3, MAX_VAL=5, en=1, up_down=1 from 0 for 7 edges -> count sequence 1,2,3,4,5,0,1; wrap_up high only on the cycle count=0; at_max high only while count=5.
- Down-count: from 1, up_down=0 for 3 edges -> count 0,5,4; wrap_dn pulses with count=5; at_min high while count=0.
- Priority: clear=1, load=1, load_val=3 and en=1 on the same edge -> count=0. Then load=1 with load_val=7 (MAX_VAL=5) -> count=5, with no pulse.
- Enable and hold: en=0 with up_down toggling for 4 edges at count=3 -> count stays 3; no pulses.
- Saturate build (UPDN_COUNTER_SATURATE_EN defined): at count=5 (MAX_VAL=5) apply two up steps -> count stays 5 and wrap_up pulses twice. At count=0 apply one down step -> count stays 0 and wrap_dn pulses once.
